// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver and transmitter:
//                FSM state encodings, the clock-counter width and a 2-of-3
//                majority helper used by the oversampling receive path.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of the per-bit clock counter (covers CLKS_PER_BIT up to 32767).
    localparam int CNT_W = 15;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_STOP       = 3'd3,
        S_CLEANUP    = 3'd4,
        S_BREAK_WAIT = 3'd5
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Generic two-flop synchronizer for an asynchronous pin.
//                Both flops reset to 1 so an idle-high line is not seen as
//                an edge when reset is released.
//  Ports       : i_Clock  - destination clock
//                i_Rst_n  - asynchronous active-low reset
//                i_D      - asynchronous input
//                o_Q      - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_meta <= 1'b1;
            o_Q    <= 1'b1;
        end else begin
            r_meta <= i_D;
            o_Q    <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Detects the start edge on the
//                synchronized line, re-checks it at mid-bit, samples eight
//                data bits LSB first at mid-bit and checks the stop bit.
//                A good frame updates o_Rx_Byte and pulses o_Rx_DV; a low
//                stop bit pulses o_Rx_Frame_Err and waits for the line to
//                return high before listening again.
//  Parameters  : CLKS_PER_BIT - clock cycles per bit (4..32767)
//  Ports       : i_Clock        - system clock (rising edge)
//                i_Rst_n        - asynchronous active-low reset
//                i_Rx_Serial    - raw serial line, idle high
//                o_Rx_DV        - one-cycle strobe, new byte on o_Rx_Byte
//                o_Rx_Byte      - last good byte, held between frames
//                o_Rx_Active    - high from start detection until IDLE
//                o_Rx_Frame_Err - one-cycle strobe, stop bit sampled low
//  Config      : UART_RX_MAJORITY_EN - when defined, each start/data/stop
//                decision is the 2-of-3 majority of samples at MID-1, MID
//                and MID+1 (decision at MID+1). Otherwise one sample at MID.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 25
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    import uart_pkg::*;

    // The counter restarts at the start-bit decision point, so from then on
    // every decision lands CLKS_PER_BIT cycles later at count LAST, which is
    // the same position within each following bit.
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] c_START_S0  = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] c_START_S1  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_START_DEC = CNT_W'((CLKS_PER_BIT - 1) / 2 + 1);
    localparam logic [CNT_W-1:0] c_BIT_S0    = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] c_BIT_S1    = CNT_W'(CLKS_PER_BIT - 2);
`else
    localparam logic [CNT_W-1:0] c_START_DEC = CNT_W'((CLKS_PER_BIT - 1) / 2);
`endif

    uart_state_t        r_state;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_rx_s;
    logic [CNT_W-1:0]   w_dec_cnt;
    logic               w_dec;
    logic               w_bit;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_D     (i_Rx_Serial),
        .o_Q     (w_rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]       r_smp;
    logic [CNT_W-1:0] w_s0_cnt;
    logic [CNT_W-1:0] w_s1_cnt;

    assign w_s0_cnt = (r_state == S_START) ? c_START_S0 : c_BIT_S0;
    assign w_s1_cnt = (r_state == S_START) ? c_START_S1 : c_BIT_S1;
    // Third vote is the live synchronized value at the decision count.
    assign w_bit    = maj3(r_smp[0], r_smp[1], w_rx_s);
`else
    assign w_bit    = w_rx_s;
`endif

    assign w_dec_cnt = (r_state == S_START) ? c_START_DEC : c_LAST;
    assign w_dec     = (r_clk_cnt == w_dec_cnt);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state        <= S_IDLE;
            r_clk_cnt      <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            r_smp          <= 2'b11;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            if (r_clk_cnt == w_s0_cnt) r_smp[0] <= w_rx_s;
            if (r_clk_cnt == w_s1_cnt) r_smp[1] <= w_rx_s;
`endif
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt   <= '0;
                    r_bit_idx   <= '0;
                    o_Rx_Active <= 1'b0;
                    if (!w_rx_s) begin
                        r_state     <= S_START;
                        o_Rx_Active <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_dec) begin
                        r_clk_cnt <= '0;
                        if (!w_bit) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            // Line was high again at mid-start: a glitch.
                            r_state     <= S_IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_dec) begin
                        r_clk_cnt          <= '0;
                        r_shift[r_bit_idx] <= w_bit;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_dec) begin
                        r_clk_cnt <= '0;
                        if (w_bit) begin
                            o_Rx_Byte <= r_shift;
                            o_Rx_DV   <= 1'b1;
                            r_state   <= S_CLEANUP;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            r_state        <= S_BREAK_WAIT;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_CLEANUP: begin
                    r_state     <= S_IDLE;
                    o_Rx_Active <= 1'b0;
                end

                // A line held low after a bad stop bit must not look like a
                // new start edge; wait for it to go high first.
                S_BREAK_WAIT: begin
                    r_clk_cnt <= '0;
                    if (w_rx_s) begin
                        r_state     <= S_IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_clk_cnt   <= '0;
                    r_bit_idx   <= '0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
